// File: rtl/any1_pkg.sv
// any1_pkg: shared types and defaults for the ANY-1 address generator.
//   agen_mode_t  - request addressing mode
//   agen_size_t  - access size encoding (byte/wyde/tetra/octa)
//   agen_state_t - sequencer state, also exported on the debug port
//   size_mask()  - low-order address bits that must be zero for a size
package any1_pkg;

  localparam int AWID_DEF = 64;
  localparam int CNTW_DEF = 8;

  typedef enum logic [1:0] {
    INDEXED = 2'd0,
    STRIDE  = 2'd1,
    UNIT    = 2'd2,
    RSVD    = 2'd3
  } agen_mode_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_WYDE  = 2'd1,
    SZ_TETRA = 2'd2,
    SZ_OCTA  = 2'd3
  } agen_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } agen_state_t;

  // (1 << size) - 1, limited to the three bits an octa can touch.
  function automatic logic [2:0] size_mask(input agen_size_t sz);
    logic [2:0] m;
    m = 3'b000;
    case (sz)
      SZ_BYTE:  m = 3'b000;
      SZ_WYDE:  m = 3'b001;
      SZ_TETRA: m = 3'b011;
      SZ_OCTA:  m = 3'b111;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/any1_agen_seq_if.sv
// any1_agen_seq_if: request and address-output bundle of the address generator.
//   i_valid/i_ready        request handshake
//   i_mode..i_cnt          request payload
//   o_valid/o_ready        address handshake
//   o_ea..o_err            address payload
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid && ready. The producer keeps valid and payload stable until that
// edge; valid never drops without a transfer. ready may depend on valid.
interface any1_agen_seq_if
  import any1_pkg::*;
#(
  parameter int AWID = AWID_DEF,
  parameter int CNTW = CNTW_DEF
);
  logic            i_valid;
  logic            i_ready;
  logic [1:0]      i_mode;
  logic [AWID-1:0] i_base;
  logic [AWID-1:0] i_index;
  logic [2:0]      i_sc;
  logic [AWID-1:0] i_disp;
  logic [1:0]      i_size;
  logic [CNTW-1:0] i_cnt;

  logic            o_valid;
  logic            o_ready;
  logic [AWID-1:0] o_ea;
  logic [CNTW-1:0] o_idx;
  logic            o_first;
  logic            o_last;
  logic            o_misalign;
  logic            o_err;

  modport slave (
    input  i_valid, i_mode, i_base, i_index, i_sc, i_disp, i_size, i_cnt, o_ready,
    output i_ready, o_valid, o_ea, o_idx, o_first, o_last, o_misalign, o_err
  );

  modport master (
    output i_valid, i_mode, i_base, i_index, i_sc, i_disp, i_size, i_cnt, o_ready,
    input  i_ready, o_valid, o_ea, o_idx, o_first, o_last, o_misalign, o_err
  );
endinterface

// File: rtl/any1_agen_ea.sv
// any1_agen_ea: combinational effective-address sum disp + base + (index << sc),
// modulo 2^AWID.
//   disp, base, index - AWID-bit operands
//   sc                - index shift amount 0..7
//   sum               - AWID-bit result
module any1_agen_ea #(
  parameter int AWID = 64
) (
  input  logic [AWID-1:0] disp,
  input  logic [AWID-1:0] base,
  input  logic [AWID-1:0] index,
  input  logic [2:0]      sc,
  output logic [AWID-1:0] sum
);
  assign sum = disp + base + (index << sc);
endmodule

// File: rtl/any1_agen_seq.sv
// any1_agen_seq: handshaked address generator. Each accepted request yields one
// effective address (INDEXED / reserved mode) or a run of element addresses
// (STRIDE / UNIT), each tagged with index, first/last, misalign and error.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - request/address channels (slave side)
//   dbg_state  - current sequencer state
module any1_agen_seq
  import any1_pkg::*;
#(
  parameter int AWID = AWID_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  any1_agen_seq_if.slave      bus,
  output agen_state_t         dbg_state
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  agen_state_t     state_q, state_d;
  logic            valid_q, valid_d;
  logic [AWID-1:0] ea_q, ea_d;
  logic [CNTW-1:0] idx_q, idx_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic            err_q, err_d;
  logic [AWID-1:0] stride_q, stride_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  agen_size_t      size_q, size_d;

  agen_mode_t      req_mode;
  logic [AWID-1:0] ea_index;
  logic [AWID-1:0] a0;
  logic [AWID-1:0] req_stride;
  logic [CNTW-1:0] req_cnt;
  logic            in_ready;
  logic            accept;
  logic            out_hs;
  logic            next_last;

  assign req_mode = agen_mode_t'(bus.i_mode);

  // STRIDE uses the scaled index as the step, so it is kept out of A0.
  assign ea_index = (req_mode == STRIDE) ? '0 : bus.i_index;

  any1_agen_ea #(.AWID(AWID)) u_ea (
    .disp  (bus.i_disp),
    .base  (bus.i_base),
    .index (ea_index),
    .sc    (bus.i_sc),
    .sum   (a0)
  );

  always_comb begin
    req_stride = '0;
    case (req_mode)
      STRIDE:  req_stride = bus.i_index << bus.i_sc;
      UNIT:    req_stride[bus.i_size] = 1'b1;
      default: req_stride = '0;
    endcase
  end

  // Scalar modes always issue one element; a zero count means one.
  always_comb begin
    req_cnt = bus.i_cnt;
    if (req_mode == INDEXED || req_mode == RSVD || bus.i_cnt == '0) begin
      req_cnt = CNT_ONE;
    end
  end

  // RUN is left as soon as the final element is loaded into the output
  // register, so that the final element is presented from IDLE and its
  // handshake can coincide with the next request's accept.
  assign in_ready = (state_q == IDLE) && (!valid_q || bus.o_ready);
  assign accept   = bus.i_valid && in_ready;
  assign out_hs   = valid_q && bus.o_ready;
  assign next_last = (idx_q + CNT_ONE) == (cnt_q - CNT_ONE);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    ea_d     = ea_q;
    idx_d    = idx_q;
    first_d  = first_q;
    last_d   = last_q;
    err_d    = err_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          valid_d  = 1'b1;
          ea_d     = a0;
          idx_d    = '0;
          first_d  = 1'b1;
          last_d   = (req_cnt == CNT_ONE);
          err_d    = (req_mode == RSVD);
          stride_d = req_stride;
          cnt_d    = req_cnt;
          size_d   = agen_size_t'(bus.i_size);
          state_d  = (req_cnt == CNT_ONE) ? IDLE : RUN;
        end else if (out_hs) begin
          valid_d = 1'b0;
        end
      end
      RUN: begin
        if (out_hs) begin
          ea_d    = ea_q + stride_q;
          idx_d   = idx_q + CNT_ONE;
          first_d = 1'b0;
          last_d  = next_last;
          if (next_last) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      ea_q     <= '0;
      idx_q    <= '0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      stride_q <= '0;
      cnt_q    <= '0;
      size_q   <= SZ_BYTE;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      ea_q     <= ea_d;
      idx_q    <= idx_d;
      first_q  <= first_d;
      last_q   <= last_d;
      err_q    <= err_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
    end
  end

  assign bus.i_ready    = in_ready;
  assign bus.o_valid    = valid_q;
  assign bus.o_ea       = ea_q;
  assign bus.o_idx      = idx_q;
  assign bus.o_first    = first_q;
  assign bus.o_last     = last_q;
  assign bus.o_err      = err_q;
  assign bus.o_misalign = |(ea_q[2:0] & size_mask(size_q));
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_any1_agen_seq.sv
module tb_any1_agen_seq;
  import any1_pkg::*;

  localparam int AWID = 64;
  localparam int CNTW = 8;

  typedef struct packed {
    logic [AWID-1:0] ea;
    logic [CNTW-1:0] idx;
    logic            first;
    logic            last;
    logic            mis;
    logic            err;
  } exp_t;
  localparam int EW = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  agen_state_t dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  any1_agen_seq_if #(.AWID(AWID), .CNTW(CNTW)) bus ();

  any1_agen_seq #(.AWID(AWID), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  bit rdy_pat[$];
  bit rdy_rand = 0;

  always @(negedge clk) cyc <= cyc + 1;

  // o_ready driver: pattern queue first, then random or always-ready.
  always @(negedge clk) begin
    if (rdy_pat.size() > 0) bus.o_ready = rdy_pat.pop_front();
    else if (rdy_rand) bus.o_ready = 1'($urandom_range(0, 1));
    else bus.o_ready = 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_push(input logic [1:0] mode, input logic [63:0] base, input logic [63:0] index,
                            input logic [63:0] disp, input logic [2:0] sc, input logic [1:0] size,
                            input logic [7:0] cnt);
    int n;
    logic [63:0] sidx, a0, step, ea, align;
    exp_t e;
    n     = (mode == 2'd0 || mode == 2'd3) ? 1 : ((cnt == 0) ? 1 : int'(cnt));
    sidx  = index << sc;
    align = (64'd1 << size) - 64'd1;
    a0    = base + disp + ((mode == 2'd1) ? 64'd0 : sidx);
    step  = (mode == 2'd1) ? sidx : (mode == 2'd2) ? (64'd1 << size) : 64'd0;
    for (int k = 0; k < n; k++) begin
      ea      = a0 + 64'(k) * step;
      e.ea    = ea;
      e.idx   = 8'(k);
      e.first = (k == 0);
      e.last  = (k == n - 1);
      e.mis   = (ea & align) != 64'd0;
      e.err   = (mode == 2'd3);
      exp_q.push_back(EW'(e));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_req(input logic [1:0] mode, input logic [63:0] base, input logic [63:0] index,
                          input logic [63:0] disp, input logic [2:0] sc, input logic [1:0] size,
                          input logic [7:0] cnt, output int acc_cyc);
    int budget;
    bit done;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_mode  = mode;
    bus.i_base  = base;
    bus.i_index = index;
    bus.i_disp  = disp;
    bus.i_sc    = sc;
    bus.i_size  = size;
    bus.i_cnt   = cnt;
    done = 0;
    budget = 0;
    acc_cyc = -1;
    while (!done) begin
      #4;
      if (bus.i_ready === 1'b1) begin
        @(posedge clk);
        acc_cyc = cyc;
        model_push(mode, base, index, disp, sc, size, cnt);
        done = 1;
      end else begin
        budget++;
        if (budget > 200) begin
          n_cmp++;
          n_err++;
          $display("FAIL accept_timeout: i_ready=%0b required 1 within 200 cycles", bus.i_ready);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  // Idle cycles scramble the payload to show it is ignored outside accept.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_mode  = 2'($urandom_range(0, 3));
      bus.i_base  = {$urandom, $urandom};
      bus.i_index = {$urandom, $urandom};
      bus.i_disp  = {$urandom, $urandom};
      bus.i_sc    = 3'($urandom_range(0, 7));
      bus.i_size  = 2'($urandom_range(0, 3));
      bus.i_cnt   = 8'($urandom_range(0, 255));
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t f, a;
    bit exp_valid;
    logic exp_rdy;
    #4;
    if (rst_n === 1'b1) begin
      exp_valid = exp_q.size() > 0;
      n_cmp++;
      if (bus.o_valid !== exp_valid) begin
        n_err++;
        $display("FAIL o_valid: got %0b expected %0b (t=%0t)", bus.o_valid, exp_valid, $time);
      end else if (exp_valid) begin
        f = exp_t'(exp_q[0]);
        a.ea = bus.o_ea; a.idx = bus.o_idx; a.first = bus.o_first;
        a.last = bus.o_last; a.mis = bus.o_misalign; a.err = bus.o_err;
        n_cmp++;
        if (a !== f) begin
          n_err++;
          $display("FAIL element: got ea=%h idx=%0d f=%b l=%b mis=%b err=%b expected ea=%h idx=%0d f=%b l=%b mis=%b err=%b",
                   a.ea, a.idx, a.first, a.last, a.mis, a.err, f.ea, f.idx, f.first, f.last, f.mis, f.err);
        end
        exp_rdy = bus.o_ready & f.last;
        n_cmp++;
        if (bus.i_ready !== exp_rdy) begin
          n_err++;
          $display("FAIL i_ready_busy: got %0b expected %0b (t=%0t)", bus.i_ready, exp_rdy, $time);
        end
        if (bus.o_ready === 1'b1) void'(exp_q.pop_front());
      end else begin
        n_cmp++;
        if (bus.i_ready !== 1'b1) begin
          n_err++;
          $display("FAIL i_ready_idle: got %0b expected 1 (t=%0t)", bus.i_ready, $time);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ca, cb, dummy;
    bit reached;
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_mode = 2'd0; bus.i_base = '0; bus.i_index = '0;
    bus.i_disp = '0; bus.i_sc = '0; bus.i_size = '0; bus.i_cnt = '0;
    bus.o_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    #1;
    check("rst_o_valid", 64'(bus.o_valid), 64'd0);
    check("rst_o_ea", bus.o_ea, 64'd0);
    check("rst_o_idx", 64'(bus.o_idx), 64'd0);
    check("rst_o_first", 64'(bus.o_first), 64'd0);
    check("rst_o_last", 64'(bus.o_last), 64'd0);
    check("rst_o_misalign", 64'(bus.o_misalign), 64'd0);
    check("rst_o_err", 64'(bus.o_err), 64'd0);
    check("rst_i_ready", 64'(bus.i_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // INDEXED: 0x1000 + (3<<3) - 8 = 0x1010, visible the cycle after accept.
    send_req(2'd0, 64'h1000, 64'd3, 64'hFFFF_FFFF_FFFF_FFF8, 3'd3, 2'd3, 8'd1, dummy);
    @(negedge clk);
    bus.i_valid = 1'b0;
    #3;
    check("indexed_ea_n1", bus.o_ea, 64'h1010);
    check("indexed_valid_n1", 64'(bus.o_valid), 64'd1);
    idle_cycles(3);

    // UNIT tetra x4.
    send_req(2'd2, 64'h2000, 64'd0, 64'd0, 3'd0, 2'd2, 8'd4, dummy);
    idle_cycles(6);

    // STRIDE with backpressure 1,0,0,1,1 on the elements (leading 1 covers the accept cycle).
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    send_req(2'd1, 64'h100, 64'h40, 64'd0, 3'd0, 2'd0, 8'd3, dummy);
    idle_cycles(8);

    // Wrap, misalign, reserved mode.
    send_req(2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'd0, 3'd0, 2'd1, 8'd2, dummy);
    idle_cycles(4);
    send_req(2'd0, 64'h1001, 64'd0, 64'd0, 3'd0, 2'd2, 8'd1, dummy);
    idle_cycles(3);
    send_req(2'd3, 64'h3000, 64'd5, 64'd4, 3'd1, 2'd0, 8'd7, dummy);
    idle_cycles(3);

    // Back-to-back: second accept lands on the last-element handshake.
    send_req(2'd2, 64'h4000, 64'd0, 64'd0, 3'd0, 2'd3, 8'd2, ca);
    send_req(2'd0, 64'h5000, 64'd2, 64'd8, 3'd2, 2'd3, 8'd9, cb);
    check("b2b_accept_gap", 64'(cb - ca), 64'd2);
    idle_cycles(4);

    // Reset in the middle of a 5-element sequence.
    send_req(2'd2, 64'h6000, 64'd0, 64'd0, 3'd0, 2'd0, 8'd5, dummy);
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      #6;
      if (exp_q.size() == 4) reached = 1;
    end
    check("rst_mid_reached_elem1", 64'(reached), 64'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst_mid_o_valid", 64'(bus.o_valid), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_rel_i_ready", 64'(bus.i_ready), 64'd1);
    check("rst_rel_o_valid", 64'(bus.o_valid), 64'd0);
    send_req(2'd2, 64'h7000, 64'd0, 64'd0, 3'd0, 2'd1, 8'd3, dummy);
    idle_cycles(5);

    // Randomized traffic with random backpressure.
    rdy_rand = 1;
    for (int r = 0; r < 40; r++) begin
      send_req(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               8'($urandom_range(0, 6)), dummy);
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(1);
    rdy_rand = 0;

    reached = 0;
    for (int i = 0; i < 300 && !reached; i++) begin
      @(negedge clk);
      #6;
      if (exp_q.size() == 0) reached = 1;
    end
    check("drain_queue_empty", 64'(reached), 64'd1);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
